// File: rtl/lap_stopwatch.sv
// Lap stopwatch: prescaled elapsed-time counter with sticky overflow
// and a first-word fall-through FIFO of captured lap times.
module lap_stopwatch #(
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0,
    parameter int LAP_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             count_i,
    input  logic             clear_i,
    input  logic             lap_i,
    input  logic             lap_rd_i,
    output logic [WIDTH-1:0] time_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] lap_time_o,
    output logic             lap_valid_o,
    output logic             lap_full_o,
    output logic             lap_drop_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW = $clog2(LAP_DEPTH);

    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] TIME_MAX = '1;
    localparam logic [WIDTH-1:0] TIME_ONE = WIDTH'(1);
    localparam logic [AW:0]      DEPTH    = (AW + 1)'(LAP_DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    logic [PW-1:0] pre_q;
    logic          tick;
    logic          at_max;

    assign tick   = count_i & ~clear_i & (pre_q == PRE_LAST);
    assign at_max = (time_o == TIME_MAX);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pre_q  <= '0;
            time_o <= '0;
            ovf_o  <= 1'b0;
        end else if (clear_i) begin
            pre_q  <= '0;
            time_o <= '0;
            ovf_o  <= 1'b0;
        end else if (count_i) begin
            pre_q <= tick ? '0 : pre_q + PRE_ONE;
            if (tick) begin
                if (!at_max) begin
                    time_o <= time_o + TIME_ONE;
                end else begin
                    ovf_o <= 1'b1;
                    if (SATURATE == 0) begin
                        time_o <= '0;
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] mem [LAP_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (cnt == DEPTH);
    assign empty = (cnt == '0);
    // A read frees a slot in the same cycle, so a full FIFO still accepts.
    assign push  = lap_i & (~full | lap_rd_i);
    assign pop   = lap_rd_i & ~empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= time_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            lap_drop_o <= 1'b0;
        end else begin
            lap_drop_o <= lap_i & full & ~lap_rd_i;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign lap_time_o  = mem[rd_ptr];
    assign lap_valid_o = ~empty;
    assign lap_full_o  = full;

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, elapsed-time counter width in bits (2..32).
REQ-002 SHALL have parameter PRESCALE, default 1, enabled clk_i cycles per count increment (1..65535).
REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap at maximum, 1 = hold at maximum.
REQ-004 SHALL have parameter LAP_DEPTH, default 4, lap FIFO entries (power of two, 2..64).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  input  1  clock; all state changes on rising edge.
REQ-007 reset_i  input  1  synchronous active-high reset.
REQ-008 count_i  input  1  level; counting enabled while high.
REQ-009 clear_i  input  1  level; zeroes time and prescaler.
REQ-010 lap_i  input  1  pulse; captures current time_o into lap FIFO.
REQ-011 lap_rd_i  input  1  pops the lap FIFO head.
REQ-012 time_o  output  WIDTH  registered elapsed count.
REQ-013 ovf_o  output  1  sticky overflow/saturation flag.
REQ-014 lap_time_o  output  WIDTH  FIFO head, first-word fall-through.
REQ-015 lap_valid_o  output  1  FIFO non-empty.
REQ-016 lap_full_o  output  1  FIFO holds LAP_DEPTH entries.
REQ-017 lap_drop_o  output  1  one-cycle pulse: a lap capture was discarded.

Function
REQ-018 Prescaler SHALL count 0..PRESCALE-1 on cycles with count_i=1 and clear_i=0; the cycle it reaches PRESCALE-1 is a tick; it then returns to 0.
REQ-019 When count_i=0, prescaler and time_o SHALL hold.
REQ-020 On a tick, time_o SHALL increment by 1 at that clock edge (PRESCALE=1: one increment per enabled cycle, visible next cycle).
REQ-021 On a tick with time_o = 2^WIDTH-1 and SATURATE=0, time_o SHALL become 0 and ovf_o SHALL become 1.
REQ-022 On a tick with time_o = 2^WIDTH-1 and SATURATE=1, time_o SHALL hold 2^WIDTH-1 and ovf_o SHALL become 1.
REQ-023 ovf_o SHALL remain 1 until clear_i or reset_i.
REQ-024 clear_i=1 SHALL set time_o, prescaler and ovf_o to 0 at next edge, with priority over count_i; it SHALL NOT affect the lap FIFO.
REQ-025 lap_i=1 SHALL write the current-cycle (pre-edge) time_o value into the FIFO, including when clear_i or a tick occurs in the same cycle.
REQ-026 lap_i when full and lap_rd_i=0 SHALL discard the capture, leave FIFO unchanged, and pulse lap_drop_o the next cycle.
REQ-027 lap_i and lap_rd_i together when full SHALL pop head and push new value; no drop.
REQ-028 lap_i and lap_rd_i together when empty SHALL push only; lap_valid_o goes 1 next cycle.
REQ-029 lap_rd_i when empty SHALL be ignored.
REQ-030 lap_time_o SHALL equal the oldest entry whenever lap_valid_o=1; its value when empty is don't-care.
REQ-031 FIFO occupancy SHALL be tracked with a count of range 0..LAP_DEPTH; pointers wrap modulo LAP_DEPTH.

Reset
REQ-032 reset_i=1 SHALL, at the next edge, set time_o=0, prescaler=0, ovf_o=0, FIFO empty (lap_valid_o=0, lap_full_o=0), lap_drop_o=0, overriding all other inputs.
REQ-033 Reset asserted mid-count or with pending laps SHALL discard all state; counting resumes from 0 on the first enabled cycle after release.

Verification
REQ-034 Defaults; count_i=1 for 10 cycles, then 0 -> time_o=10 and holds; ovf_o=0.
REQ-035 PRESCALE=3; count_i=1 for 9 cycles -> time_o=3; drop count_i at prescaler=1, restore -> next increment after 2 more enabled cycles.
REQ-036 WIDTH=4, SATURATE=0; count 17 cycles -> time_o=1, ovf_o=1; SATURATE=1 same stimulus -> time_o=15, ovf_o=1; clear_i 1 cycle -> time_o=0, ovf_o=0.
REQ-037 Counting with lap_i at time_o=3,5,7 and clear_i in same cycle as last lap -> FIFO pops 3,5,7 in order; time_o=0 after clear.
REQ-038 LAP_DEPTH=4; 5 laps without reads -> lap_full_o=1, one lap_drop_o pulse, pops return first 4 values; lap+read when full -> no drop, occupancy stays 4.
REQ-039 reset_i during counting with 2 queued laps -> next cycle time_o=0, lap_valid_o=0, ovf_o=0.
